// File: rtl/pc_fetch_unit_if.sv
// Bus bundle between the fetch unit, the branch/return logic, instruction memory and IF/ID.
// The fetch unit uses the master view; the surrounding pipeline and memory use the slave view.
interface pc_fetch_unit_if;
  logic       stall;
  logic       pc_branch_taken;
  logic [7:0] branch_target;
  logic       ret_valid;
  logic [7:0] ret_target;
  logic       rti_done;
  logic       intr;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] pc;
  logic [7:0] pc_plus1;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       flush;
  logic       int_ack;
  logic [7:0] int_ret_addr;

  modport master (
    input  stall, pc_branch_taken, branch_target, ret_valid, ret_target,
           rti_done, intr, imem_rdata,
    output imem_addr, pc, pc_plus1, instr_out, instr_valid, flush,
           int_ack, int_ret_addr
  );

  modport slave (
    output stall, pc_branch_taken, branch_target, ret_valid, ret_target,
           rti_done, intr, imem_rdata,
    input  imem_addr, pc, pc_plus1, instr_out, instr_valid, flush,
           int_ack, int_ret_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the 8-bit PC, loads reset/interrupt vectors from imem,
// applies branch/return redirects and sequences interrupt entry.
module pc_fetch_unit #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    ST_RST_VEC = 2'd0,
    ST_RUN     = 2'd1,
    ST_INT_VEC = 2'd2
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_pc, w_pc_next;
  logic [7:0] r_int_ret_addr, w_int_ret_addr_next;
  logic       r_int_ack;
  logic       r_int_pending, w_int_pending_next;
  logic       r_int_en, w_int_en_next;

  logic       w_redirect;
  logic [7:0] w_redirect_target;
  logic       w_take_int;
  logic       w_instr_valid;
  logic [7:0] w_imem_addr;

  always_comb begin
    w_redirect          = bus.ret_valid | bus.pc_branch_taken;
    w_redirect_target   = bus.ret_valid ? bus.ret_target : bus.branch_target;
    // A redirect from an older instruction wins; the interrupt stays pending.
    w_take_int          = (r_state == ST_RUN) & r_int_pending & r_int_en
                          & ~bus.stall & ~w_redirect;

    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_int_ret_addr_next = r_int_ret_addr;
    w_int_en_next       = r_int_en;
    w_int_pending_next  = r_int_pending | (bus.intr & r_int_en);
    w_imem_addr         = r_pc;
    w_instr_valid       = 1'b0;

    case (r_state)
      ST_RST_VEC: begin
        w_imem_addr  = RESET_VEC_ADDR;
        w_pc_next    = bus.imem_rdata;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_imem_addr   = r_pc;
        w_instr_valid = ~w_redirect & ~w_take_int;
        if (w_redirect) begin
          w_pc_next = w_redirect_target;
        end else if (w_take_int) begin
          w_int_ret_addr_next = r_pc;
          w_int_en_next       = 1'b0;
          w_int_pending_next  = 1'b0;
          w_state_next        = ST_INT_VEC;
        end else if (!bus.stall) begin
          w_pc_next = r_pc + 8'd1;
        end
      end
      ST_INT_VEC: begin
        w_imem_addr  = INT_VEC_ADDR;
        w_pc_next    = bus.imem_rdata;
        w_state_next = ST_RUN;
        // An in-flight redirect means the ISR must return to its target instead.
        if (w_redirect) begin
          w_int_ret_addr_next = w_redirect_target;
        end
      end
      default: begin
        w_state_next = ST_RST_VEC;
      end
    endcase

    if (bus.rti_done) begin
      w_int_en_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RST_VEC;
      r_pc           <= 8'h00;
      r_int_ret_addr <= 8'h00;
      r_int_ack      <= 1'b0;
      r_int_pending  <= 1'b0;
      r_int_en       <= 1'b1;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_int_ret_addr <= w_int_ret_addr_next;
      r_int_ack      <= (r_state == ST_INT_VEC);
      r_int_pending  <= w_int_pending_next;
      r_int_en       <= w_int_en_next;
    end
  end

  assign bus.imem_addr    = w_imem_addr;
  assign bus.pc           = r_pc;
  assign bus.pc_plus1     = r_pc + 8'd1;
  assign bus.instr_out    = (r_state == ST_RUN) ? bus.imem_rdata : 8'h00;
  assign bus.instr_valid  = w_instr_valid & ~rst;
  assign bus.flush        = w_redirect & (r_state != ST_RST_VEC) & ~rst;
  assign bus.int_ack      = r_int_ack;
  assign bus.int_ret_addr = r_int_ret_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset vector, wrap/stall, redirects,
// interrupt entry/re-entry, redirect and reset during interrupt vector fetch.
module tb_pc_fetch_unit;
  logic clk;
  logic rst;
  logic [7:0] imem [0:255];
  int checks;
  int errors;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VEC_ADDR (8'h00),
    .INT_VEC_ADDR   (8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_rdata = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.pc_branch_taken = 1'b0;
    bus.branch_target   = 8'h00;
    bus.ret_valid       = 1'b0;
    bus.ret_target      = 8'h00;
    bus.rti_done        = 1'b0;
    bus.intr            = 1'b0;
  endtask

  // Leaves the bench 1 time unit into the single RST_VEC cycle.
  task automatic do_reset(input logic [7:0] vec);
    imem[0] = vec;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    imem[0] = 8'h10;
    rst = 1'b1;
    bus.pc_branch_taken = 1'b1;
    bus.branch_target   = 8'h77;
    step();
    step();
    #1;
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_imem_addr got %h exp %h", bus.imem_addr, 8'h00); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b exp %b", bus.instr_valid, 1'b0); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp %b", bus.flush, 1'b0); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.pc, 8'h00); end
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL rst_int_ack got %b exp %b", bus.int_ack, 1'b0); end
    checks++; if (bus.int_ret_addr !== 8'h00) begin errors++; $display("FAIL rst_int_ret got %h exp %h", bus.int_ret_addr, 8'h00); end
    bus.pc_branch_taken = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rstvec_imem_addr got %h exp %h", bus.imem_addr, 8'h00); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstvec_instr_valid got %b exp %b", bus.instr_valid, 1'b0); end
    step();
    checks++; if (bus.pc !== 8'h10) begin errors++; $display("FAIL run_pc0 got %h exp %h", bus.pc, 8'h10); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL run_instr_valid got %b exp %b", bus.instr_valid, 1'b1); end
    checks++; if (bus.imem_addr !== 8'h10) begin errors++; $display("FAIL run_imem_addr got %h exp %h", bus.imem_addr, 8'h10); end
    checks++; if (bus.instr_out !== 8'hB5) begin errors++; $display("FAIL run_instr_out got %h exp %h", bus.instr_out, 8'hB5); end
    step();
    checks++; if (bus.pc !== 8'h11) begin errors++; $display("FAIL run_pc1 got %h exp %h", bus.pc, 8'h11); end
    step();
    checks++; if (bus.pc !== 8'h12) begin errors++; $display("FAIL run_pc2 got %h exp %h", bus.pc, 8'h12); end
    $display("test_reset done: pc=%h", bus.pc);
  endtask

  task automatic test_wrap_and_stall();
    do_reset(8'hFE);
    step();
    checks++; if (bus.pc !== 8'hFE) begin errors++; $display("FAIL wrap_pc_fe got %h exp %h", bus.pc, 8'hFE); end
    step();
    checks++; if (bus.pc !== 8'hFF) begin errors++; $display("FAIL wrap_pc_ff got %h exp %h", bus.pc, 8'hFF); end
    checks++; if (bus.pc_plus1 !== 8'h00) begin errors++; $display("FAIL wrap_pc_plus1 got %h exp %h", bus.pc_plus1, 8'h00); end
    step();
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc_00 got %h exp %h", bus.pc, 8'h00); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, bus.pc, 8'h00); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp %b", i, bus.instr_valid, 1'b1); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL unstall_pc got %h exp %h", bus.pc, 8'h01); end
    $display("test_wrap_and_stall done: pc=%h", bus.pc);
  endtask

  task automatic test_branch_over_stall();
    bus.stall = 1'b1;
    bus.pc_branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp %b", bus.flush, 1'b1); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp %b", bus.instr_valid, 1'b0); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.pc !== 8'h40) begin errors++; $display("FAIL br_pc got %h exp %h", bus.pc, 8'h40); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL br_flush_after got %b exp %b", bus.flush, 1'b0); end
    $display("test_branch_over_stall done: pc=%h", bus.pc);
  endtask

  task automatic test_ret_priority();
    bus.ret_valid = 1'b1;
    bus.ret_target = 8'h22;
    bus.pc_branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL ret_flush got %b exp %b", bus.flush, 1'b1); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.pc !== 8'h22) begin errors++; $display("FAIL ret_pc got %h exp %h", bus.pc, 8'h22); end
    $display("test_ret_priority done: pc=%h", bus.pc);
  endtask

  task automatic test_interrupt();
    do_reset(8'h15);
    bus.intr = 1'b1;
    step();
    bus.intr = 1'b0;
    #1;
    checks++; if (bus.pc !== 8'h15) begin errors++; $display("FAIL int_pc_take got %h exp %h", bus.pc, 8'h15); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL int_take_valid got %b exp %b", bus.instr_valid, 1'b0); end
    step();
    checks++; if (bus.imem_addr !== 8'h01) begin errors++; $display("FAIL int_vec_addr got %h exp %h", bus.imem_addr, 8'h01); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL int_vec_valid got %b exp %b", bus.instr_valid, 1'b0); end
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL int_ack_early got %b exp %b", bus.int_ack, 1'b0); end
    step();
    bus.intr = 1'b1;
    #1;
    checks++; if (bus.pc !== 8'h80) begin errors++; $display("FAIL int_isr_pc got %h exp %h", bus.pc, 8'h80); end
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL int_ack got %b exp %b", bus.int_ack, 1'b1); end
    checks++; if (bus.int_ret_addr !== 8'h15) begin errors++; $display("FAIL int_ret_addr got %h exp %h", bus.int_ret_addr, 8'h15); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL int_isr_valid got %b exp %b", bus.instr_valid, 1'b1); end
    step();
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL int_ack_pulse got %b exp %b", bus.int_ack, 1'b0); end
    checks++; if (bus.pc !== 8'h81) begin errors++; $display("FAIL int_isr_pc1 got %h exp %h", bus.pc, 8'h81); end
    step();
    bus.intr = 1'b0;
    bus.rti_done = 1'b1;
    #1;
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL int_masked_valid got %b exp %b", bus.instr_valid, 1'b1); end
    step();
    bus.rti_done = 1'b0;
    bus.intr = 1'b1;
    #1;
    checks++; if (bus.pc !== 8'h83) begin errors++; $display("FAIL int_masked_pc got %h exp %h", bus.pc, 8'h83); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL int_reen_valid got %b exp %b", bus.instr_valid, 1'b1); end
    step();
    bus.intr = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL int2_take_valid got %b exp %b", bus.instr_valid, 1'b0); end
    step();
    step();
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL int2_ack got %b exp %b", bus.int_ack, 1'b1); end
    checks++; if (bus.int_ret_addr !== 8'h84) begin errors++; $display("FAIL int2_ret_addr got %h exp %h", bus.int_ret_addr, 8'h84); end
    checks++; if (bus.pc !== 8'h80) begin errors++; $display("FAIL int2_isr_pc got %h exp %h", bus.pc, 8'h80); end
    $display("test_interrupt done: pc=%h ret=%h", bus.pc, bus.int_ret_addr);
  endtask

  task automatic test_int_vec_redirect_and_reset();
    do_reset(8'h15);
    bus.intr = 1'b1;
    step();
    bus.intr = 1'b0;
    step();
    bus.pc_branch_taken = 1'b1;
    bus.branch_target = 8'h33;
    #1;
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL iv_flush got %b exp %b", bus.flush, 1'b1); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.pc !== 8'h80) begin errors++; $display("FAIL iv_pc got %h exp %h", bus.pc, 8'h80); end
    checks++; if (bus.int_ack !== 1'b1) begin errors++; $display("FAIL iv_ack got %b exp %b", bus.int_ack, 1'b1); end
    checks++; if (bus.int_ret_addr !== 8'h33) begin errors++; $display("FAIL iv_ret_addr got %h exp %h", bus.int_ret_addr, 8'h33); end

    do_reset(8'h15);
    bus.intr = 1'b1;
    step();
    bus.intr = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL ivr_ack got %b exp %b", bus.int_ack, 1'b0); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL ivr_imem_addr got %h exp %h", bus.imem_addr, 8'h00); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL ivr_pc got %h exp %h", bus.pc, 8'h00); end
    checks++; if (bus.int_ret_addr !== 8'h00) begin errors++; $display("FAIL ivr_ret got %h exp %h", bus.int_ret_addr, 8'h00); end
    step();
    checks++; if (bus.pc !== 8'h15) begin errors++; $display("FAIL ivr_pc_restart got %h exp %h", bus.pc, 8'h15); end
    checks++; if (bus.int_ack !== 1'b0) begin errors++; $display("FAIL ivr_ack_late got %b exp %b", bus.int_ack, 1'b0); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ivr_no_pending got %b exp %b", bus.instr_valid, 1'b1); end
    $display("test_int_vec_redirect_and_reset done: pc=%h", bus.pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) imem[i] = 8'(i) ^ 8'hA5;
    imem[1] = 8'h80;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_wrap_and_stall();
    test_branch_over_stall();
    test_ret_priority();
    test_interrupt();
    test_int_vec_redirect_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the branch resolution logic. Holds the 8-bit program counter and drives the instruction-memory address.
- Consumes branch redirects (pc_branch_taken/branch_target) and RET/RTI return targets.
- Loads the reset and interrupt vectors from instruction memory, and sequences interrupt entry.
- Presents the fetched instruction and a squash (flush) signal to the IF/ID register.

Parameters:
RESET_VEC_ADDR, 8'h00, imem address holding the reset start PC
INT_VEC_ADDR, 8'h01, imem address holding the ISR start PC

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard stall; hold PC
pc_branch_taken  input  1  redirect request from branch unit
branch_target  input  8  redirect target
ret_valid  input  1  RET/RTI resolved this cycle
ret_target  input  8  popped return address
rti_done  input  1  one-cycle pulse; RTI completed, re-enable interrupts
intr  input  1  external interrupt request, level
imem_addr  output  8  instruction memory address, combinational
imem_rdata  input  8  instruction memory data, combinational read of imem_addr
pc  output  8  current PC register
pc_plus1  output  8  pc+1 mod 256; CALL return address
instr_out  output  8  fetched instruction (= imem_rdata in RUN)
instr_valid  output  1  instr_out is to be latched into IF/ID
flush  output  1  squash younger pipeline stages, combinational
int_ack  output  1  one-cycle pulse; push int_ret_addr, save flags
int_ret_addr  output  8  ISR return address

Behaviour:
- FSM states:
  - RST_VEC: imem_addr=RESET_VEC_ADDR.
  - RUN: imem_addr=pc.
  - INT_VEC: imem_addr=INT_VEC_ADDR.
- Reset (any cycle, including mid-interrupt-entry):
  - state=RST_VEC; pc=0, int_ret_addr=0, int_ack=0.
  - int_pending=0, int_en=1.
  - While in reset: instr_valid=0, flush=0.
- RST_VEC: pc<=imem_rdata, go to RUN; instr_valid=0. Exactly one cycle.
- Redirect = ret_valid | pc_branch_taken.
  - flush = redirect, in any state except RST_VEC.
  - instr_valid = (state==RUN) & ~redirect & ~take_int.
- RUN next-PC priority (highest first):
  1. ret_valid: pc<=ret_target.
  2. pc_branch_taken: pc<=branch_target.
  3. take_int = int_pending & int_en & ~stall: int_ret_addr<=pc (current instruction not issued), int_en<=0, int_pending<=0, go to INT_VEC.
  4. stall: hold pc.
  5. Otherwise pc<=pc+1, wrapping 8'hFF->8'h00.
- Redirect overrides stall. ret_valid overrides pc_branch_taken in the same cycle.
- int_pending is set on any cycle with intr=1 and int_en=1; it stays set until taken.
- INT_VEC (exactly one cycle):
  - pc<=imem_rdata; go to RUN.
  - If a redirect arrives in this cycle (older in-flight branch/RET), int_ret_addr<=redirect target using the same priority; pc still takes the vector.
- int_ack: registered; high for the first RUN cycle after INT_VEC only. int_ret_addr is stable while int_ack=1.
- rti_done sets int_en<=1. A take needs int_en=1 in the current cycle, so the earliest re-entry is the cycle after rti_done.
- pc_plus1 = pc+1 mod 256, combinational.

Test Plan:
1. imem[0]=8'h10, rst high 2 cycles then low -> one RST_VEC cycle with imem_addr=8'h00, instr_valid=0; then pc=8'h10, instr_valid=1, pc increments 8'h11, 8'h12.
2. Preload pc=8'hFE with stall=0 -> pc sequence 8'hFF, 8'h00; pc_plus1=8'h00 when pc=8'hFF; stall=1 for 3 cycles holds pc constant with instr_valid=1.
3. stall=1 and pc_branch_taken=1, branch_target=8'h40 -> flush=1 and instr_valid=0 that cycle; pc=8'h40 next cycle.
4. ret_valid=1, ret_target=8'h22, with pc_branch_taken=1, branch_target=8'h40 in the same cycle -> pc=8'h22.
5. imem[1]=8'h80, intr pulsed at pc=8'h15 (no stall) -> instr_valid=0, INT_VEC; pc=8'h80; int_ack=1 for one cycle with int_ret_addr=8'h15. A second intr is ignored until the cycle after rti_done, then taken.
6. pc_branch_taken=1, branch_target=8'h33 during the INT_VEC cycle -> pc=8'h80, int_ret_addr=8'h33 at int_ack. Assert rst in the INT_VEC cycle instead -> int_ack never fires, and the RST_VEC sequence restarts.
